// File: rtl/fp_addsub_pipe.sv
// Five-stage pipelined floating-point adder/subtractor: RNE rounding, flush-to-zero
// subnormals, IEEE-style status flags and one global stall for backpressure.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic [3:0]           flags
);
    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned SHX_W   = MAN_W + 3;
    localparam int unsigned EXT_W   = MAN_W + 4;
    localparam int unsigned SUM_W   = MAN_W + 5;
    localparam int unsigned LZ_W    = $clog2(EXT_W + 1);
    localparam int unsigned EN_W    = EXP_W + LZ_W + 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    function automatic logic [LZ_W-1:0] lzc(input logic [EXT_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(EXT_W);
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (v[i]) n = LZ_W'(int'(EXT_W) - 1 - i);
        end
        return n;
    endfunction

    // Stage registers
    logic             v1, v2, v3, v4;
    logic             s1_sign, s1_esub, s1_spec, s1_inv;
    logic [EXP_W-1:0] s1_exp_l, s1_exp_s;
    logic [SIG_W-1:0] s1_sig_l, s1_sig_s;
    logic [W-1:0]     s1_spec_y;
    logic             s2_sign, s2_esub, s2_spec, s2_inv;
    logic [EXP_W-1:0] s2_exp;
    logic [EXT_W-1:0] s2_a_ext, s2_b_ext;
    logic [W-1:0]     s2_spec_y;
    logic             s3_sign, s3_esub, s3_spec, s3_inv;
    logic [EXP_W-1:0] s3_exp;
    logic [SUM_W-1:0] s3_sum;
    logic [W-1:0]     s3_spec_y;
    logic             s4_sign, s4_zero, s4_spec, s4_inv;
    logic [EN_W-1:0]  s4_exp;
    logic [EXT_W-1:0] s4_norm;
    logic [W-1:0]     s4_spec_y;

    // S1: unpack, flush subnormals, classify specials, order by magnitude
    logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_f, b_f;
    logic             n1_spec, n1_inv;
    logic [W-1:0]     n1_spec_y;

    always_comb begin
        a_s       = a[W-1];
        b_s       = b[W-1] ^ sub;
        a_e       = a[W-2:MAN_W];
        b_e       = b[W-2:MAN_W];
        a_f       = (a_e == '0) ? '0 : a[MAN_W-1:0];
        b_f       = (b_e == '0) ? '0 : b[MAN_W-1:0];
        a_nan     = (a_e == '1) && (a_f != '0);
        b_nan     = (b_e == '1) && (b_f != '0);
        a_inf     = (a_e == '1) && (a_f == '0);
        b_inf     = (b_e == '1) && (b_f == '0);
        a_snan    = a_nan && !a_f[MAN_W-1];
        b_snan    = b_nan && !b_f[MAN_W-1];
        swap      = {b_e, b_f} > {a_e, a_f};
        n1_spec   = 1'b1;
        n1_inv    = 1'b0;
        n1_spec_y = QNAN;
        if (a_nan || b_nan) begin
            n1_inv = a_snan || b_snan;
        end else if (a_inf && b_inf && (a_s != b_s)) begin
            n1_inv = 1'b1;
        end else if (a_inf) begin
            n1_spec_y = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            n1_spec_y = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            n1_spec = 1'b0;
        end
    end

    // S2: align the smaller significand, keeping guard/round and a sticky OR
    logic [EXP_W-1:0] diff;
    logic [SHX_W-1:0] sh_in, sh_out;
    logic             sticky;

    always_comb begin
        diff   = s1_exp_l - s1_exp_s;
        sh_in  = {s1_sig_s, 2'b00};
        sh_out = '0;
        sticky = |sh_in;
        if (32'(diff) < SHX_W) begin
            sh_out = sh_in >> diff;
            sticky = |(sh_in & ~({SHX_W{1'b1}} << diff));
        end
    end

    // S3: magnitude add or subtract; A >= B so the difference never goes negative
    logic [SUM_W-1:0] n3_sum;
    assign n3_sum = s2_esub ? ({1'b0, s2_a_ext} - {1'b0, s2_b_ext})
                            : ({1'b0, s2_a_ext} + {1'b0, s2_b_ext});

    // S4: normalise; an exact cancellation is +0 unless both operands were -0
    logic [LZ_W-1:0]  lz;
    logic             n4_zero, n4_sign;
    logic [EXT_W-1:0] n4_norm;
    logic [EN_W-1:0]  n4_exp;

    always_comb begin
        lz      = lzc(s3_sum[EXT_W-1:0]);
        n4_zero = (s3_sum == '0);
        n4_sign = n4_zero ? (s3_sign && !s3_esub) : s3_sign;
        if (s3_sum[SUM_W-1]) begin
            n4_norm = {s3_sum[SUM_W-1:2], s3_sum[1] | s3_sum[0]};
            n4_exp  = EN_W'(s3_exp) + EN_W'(1);
        end else begin
            n4_norm = s3_sum[EXT_W-1:0] << lz;
            n4_exp  = EN_W'(s3_exp) - EN_W'(lz);
        end
    end

    // S5: round to nearest even, then resolve specials, zero, underflow, overflow
    logic             inc, inexact, uflow, oflow;
    logic [SIG_W:0]   rnd;
    logic [EN_W-1:0]  exp_r;
    logic [MAN_W-1:0] frac_r;
    logic [W-1:0]     n5_y;
    logic [3:0]       n5_flags;

    always_comb begin
        inc      = s4_norm[2] && (s4_norm[1] || s4_norm[0] || s4_norm[3]);
        rnd      = {1'b0, s4_norm[EXT_W-1:3]} + (SIG_W+1)'(inc);
        exp_r    = s4_exp + EN_W'(rnd[SIG_W]);
        frac_r   = rnd[SIG_W] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        inexact  = |s4_norm[2:0];
        uflow    = s4_exp[EN_W-1] || (s4_exp == '0);
        oflow    = !exp_r[EN_W-1] && (exp_r >= EN_W'(EXP_MAX));
        n5_y     = {s4_sign, exp_r[EXP_W-1:0], frac_r};
        n5_flags = {3'b000, inexact};
        if (s4_spec) begin
            n5_y     = s4_spec_y;
            n5_flags = {s4_inv, 3'b000};
        end else if (s4_zero) begin
            n5_y     = {s4_sign, {(W-1){1'b0}}};
            n5_flags = 4'b0000;
        end else if (uflow) begin
            n5_y     = {s4_sign, {(W-1){1'b0}}};
            n5_flags = 4'b0011;
        end else if (oflow) begin
            n5_y     = {s4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            n5_flags = 4'b0101;
        end
    end

    // Valids and architected outputs; y/flags only move when a valid op retires
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (v4) begin
                y     <= n5_y;
                flags <= n5_flags;
            end
        end
    end

    // Datapath registers carry don't-care contents in bubbles
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign   <= swap ? b_s : a_s;
            s1_esub   <= a_s ^ b_s;
            s1_exp_l  <= swap ? b_e : a_e;
            s1_exp_s  <= swap ? a_e : b_e;
            s1_sig_l  <= swap ? {b_e != '0, b_f} : {a_e != '0, a_f};
            s1_sig_s  <= swap ? {a_e != '0, a_f} : {b_e != '0, b_f};
            s1_spec   <= n1_spec;
            s1_inv    <= n1_inv;
            s1_spec_y <= n1_spec_y;

            s2_sign   <= s1_sign;
            s2_esub   <= s1_esub;
            s2_exp    <= s1_exp_l;
            s2_a_ext  <= {s1_sig_l, 3'b000};
            s2_b_ext  <= {sh_out, sticky};
            s2_spec   <= s1_spec;
            s2_inv    <= s1_inv;
            s2_spec_y <= s1_spec_y;

            s3_sign   <= s2_sign;
            s3_esub   <= s2_esub;
            s3_exp    <= s2_exp;
            s3_sum    <= n3_sum;
            s3_spec   <= s2_spec;
            s3_inv    <= s2_inv;
            s3_spec_y <= s2_spec_y;

            s4_sign   <= n4_sign;
            s4_zero   <= n4_zero;
            s4_exp    <= n4_exp;
            s4_norm   <= n4_norm;
            s4_spec   <= s3_spec;
            s4_inv    <= s3_inv;
            s4_spec_y <= s3_spec_y;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: vector table through a scoreboard, plus backpressure,
// reset-flush and half-precision sequences.
module tb_fp_addsub_pipe;
    localparam int NV = 19;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] y;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, y;
    logic [3:0]  flags;
    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_y;
    logic [3:0]  h_flags;

    logic [31:0] drv_y;
    logic [3:0]  drv_f;
    bit          lat_mode;
    exp_t        sb[$];
    vec_t        vecs[NV];
    int          total = 0, bad = 0, cyc = 0, n_out = 0, n_out_snap;
    int          bp_i, bp_k;
    logic        bp_acc;
    logic        prev_stall = 1'b0, prev_ov;
    logic [31:0] prev_y;
    logic [3:0]  prev_f;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .y(h_y), .flags(h_flags)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t r;
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_y", y, prev_y);
                chk("stall_flags", 32'(flags), 32'(prev_f));
                chk("stall_valid", 32'(out_valid), 32'(prev_ov));
            end
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", y, 32'hDEAD_0000);
                end else begin
                    r = sb.pop_front();
                    chk("y", y, r.y);
                    chk("flags", 32'(flags), 32'(r.f));
                    if (r.lat) chk("latency", 32'(cyc - r.cyc), 32'd5);
                end
            end
            if (in_valid && in_ready) sb.push_back('{drv_y, drv_f, cyc, lat_mode});
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_f     = flags;
            prev_ov    = out_valid;
        end
    end

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; sub = v.sub; drv_y = v.y; drv_f = v.f; in_valid = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            next_cycle();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_y"}, y, 32'd0);
        chk({nm, "_flags"}, 32'(flags), 32'd0);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic half_op(input logic [15:0] ha, input logic [15:0] hb,
                           input logic [15:0] ey, input logic [3:0] ef);
        int n;
        h_a = ha; h_b = hb; h_in_valid = 1'b1;
        next_cycle();
        h_in_valid = 1'b0;
        n = 1;
        while (!h_out_valid && n < 20) begin
            next_cycle();
            n++;
        end
        chk("half_valid", 32'(h_out_valid), 32'd1);
        chk("half_latency", 32'(n), 32'd5);
        chk("half_y", 32'(h_y), 32'(ey));
        chk("half_flags", 32'(h_flags), 32'(ef));
    endtask

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h41000000, 1'b0, 32'h41600000, 4'b0000};
        vecs[1]  = '{32'h41000000, 32'h40C00000, 1'b1, 32'h40000000, 4'b0000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[3]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
        vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[6]  = '{32'h7F800000, 32'hC0C00000, 1'b0, 32'h7F800000, 4'b0000};
        vecs[7]  = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[10] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[12] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vecs[13] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000};
        vecs[14] = '{32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 4'b0000};
        vecs[15] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0000};
        vecs[16] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[17] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000};
        vecs[18] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        drv_y = '0; drv_f = '0; lat_mode = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        chk_reset_state("init");

        // Backpressure: 8 ops offered every cycle, consumer stalls cycles 6..9
        lat_mode = 1'b0;
        bp_i = 0;
        bp_k = 0;
        while (bp_i < 8 && bp_k < 40) begin
            out_ready = !(bp_k >= 6 && bp_k <= 9);
            drive(vecs[bp_i]);
            #1;
            bp_acc = in_ready;
            next_cycle();
            bp_k++;
            if (bp_acc) bp_i++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_issued", 32'(bp_i), 32'd8);
        chk("bp_cycles", 32'(bp_k), 32'd12);
        drain(30);

        // Whole table back to back with latency checked
        lat_mode = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            next_cycle();
        end
        in_valid = 1'b0;
        drain(30);

        // Reset with three ops in flight: they must never retire
        for (int i = 2; i < 5; i++) begin
            drive(vecs[i]);
            next_cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk_reset_state("rst_flush");
        n_out_snap = n_out;
        repeat (10) next_cycle();
        chk("rst_no_results", 32'(n_out), 32'(n_out_snap));

        // Half precision instance
        half_op(16'h3C00, 16'h3C00, 16'h4000, 4'b0000);
        half_op(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);
        half_op(16'h3C00, 16'h4000, 16'h4200, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control, round-to-nearest-even and exception flags. It is the next generation of the team's pipelined FP adder and sits in the FP datapath, where it accepts one operation per cycle when not stalled. It generalises the format widths, adds a subtract mode, backpressure, correct rounding and status flags.

## Interface
- EXP_W, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- sub  in  1  0: a+b, 1: a-b (flips b sign at unpack)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  W  result
- flags  out  4  {invalid, overflow, underflow, inexact} for y

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stages:
  - S1: unpack; hidden bit = (exp!=0). Exp==0 inputs are treated as ±0, so subnormals flush to zero. Apply sub. Swap so A has the larger {exp,frac} magnitude. Classify NaN/Inf/zero.
  - S2: right-shift the smaller significand by the exp difference. Extend it with guard, round and sticky bits, where sticky = OR of all shifted-out bits. A difference ≥ MAN_W+3 leaves only sticky.
  - S3: add the significands if the effective signs are equal, else subtract (A−B, which is always ≥0). Width MAN_W+5 including the carry bit.
  - S4: normalise. On carry, shift right 1 and fold the LSB into sticky, exp+1. Otherwise apply a leading-zero count and shift left, exp−lzc. A zero magnitude gives exact zero.
  - S5: round to nearest even: increment if G && (R||S||LSB). A rounding carry renormalises, exp+1. Pack; y/flags are registered here.
- Special cases, by priority:
  - Any NaN input → y = quiet NaN {0, all-ones, 1 followed by zeros}, invalid=1 only if an input was signalling (frac MSB=0).
  - +Inf + −Inf (after sub) → quiet NaN, invalid=1.
  - Otherwise, a single Inf passes through with its sign.
  - Exact-zero result of opposite-sign operands → +0. (−0)+(−0) → −0.
- Overflow: biased exp ≥ all-ones after rounding → ±Inf, overflow=1, inexact=1.
- Underflow: normalised biased exp ≤ 0 → ±0, underflow=1, inexact=1 (flush-to-zero).
- inexact = G|R|S before rounding, and also set on overflow or underflow. Flags are all zero for NaN/Inf passthrough except as stated above.

## Timing
- Latency: exactly 5 clk from accepting the transfer to out_valid for that op, when unstalled. Throughput is 1 op/cycle.
- Global stall = out_valid && !out_ready.
  - While stalled, every stage register, its valid bit, y and flags hold.
  - in_ready = !stall, combinational; no combinational path from in_valid.
- Bubbles propagate as invalid stages. Data in invalid stages is don't-care, but y/flags hold their last value when no valid op is present.
- Ordering is strict FIFO. There is no internal buffering beyond the 5 stages.
- Reset takes effect on the next clk edge regardless of stall. All stage valids → 0, out_valid=0, y=0, flags=0, in_ready=1 in the cycle after reset. In-flight ops are discarded.
- While in_valid=0, a, b and sub are ignored.

## Test plan
- Back-to-back, defaults, out_ready=1:
  - 0x40C00000+0x41000000 (6+8) → 0x41600000.
  - Next cycle 0x41000000 − 0x40C00000 with sub=1 → 0x40000000.
  - Both arrive 5 and 6 cycles after input, flags=0.
- Rounding:
  - 0x3F800000+0x33800000 (tie) → 0x3F800000, inexact=1.
  - 0x3F800000+0x33800001 → 0x3F800001, inexact=1.
  - 0x3F800001+0x33800000 (tie, odd) → 0x3F800002.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x7F800000 + 0xC0C00000 → 0x7F800000, flags=0.
  - 0x40400000 − 0x40400000 → 0x00000000, flags=0.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Overflow and underflow:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x00800001 − 0x00800000 → 0x00000000, underflow=1, inexact=1.
- Backpressure:
  - Issue 8 ops every cycle, hold out_ready=0 for cycles 6–9 after the first input.
  - Required: in_ready=0 while stalled, y/out_valid stable, no op lost or duplicated, results in order.
- Reset: assert rst for 1 cycle with 3 ops in flight → out_valid=0, y=0, flags=0 next cycle, and none of the 3 results ever appear.
- Parametrised instance EXP_W=5, MAN_W=10 (half precision): 0x3C00+0x3C00 → 0x4000, and 0x7BFF+0x7BFF → 0x7C00 with overflow=1.
